pipelined_multi_adder: RTL and testbench
========================================

# pipelined_multi_adder

Parametrised, pipelined N-operand modulo-2^WIDTH adder with valid/ready handshake. It reduces N_OPS operands plus a carry-in through a carry-save (3:2) compressor tree, then resolves the result in a pipelined carry-look-ahead stage. It returns the WIDTH-bit sum and the full-precision overflow count. It is the shared adder for the SHA-256 round datapath, e.g. T1 = h + Σ1 + Ch + K + W as one 5-operand add.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits; at least 4 and even.
- N_OPS, 5, number of operands, 2..8.
- STAGES, 2, pipeline register stages, 1..3.
- CW (derived, local), max(1, clog2(N_OPS)), overflow-count width.

Ports:
- i_clk  in  1  sole clock; all state on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block accepts input this cycle.
- i_ops  in  N_OPS*WIDTH  packed operands; operand k at bits [k*WIDTH +: WIDTH].
- i_carry  in  1  carry-in, added as +1.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_summ  out  WIDTH  (Σ ops + i_carry) mod 2^WIDTH.
- o_carry  out  CW  floor((Σ ops + i_carry) / 2^WIDTH). The maximum value is N_OPS-1, so CW bits are sufficient.

## Operation
- **Arithmetic:** the exact unsigned sum is formed at WIDTH+CW bits. There is no saturation. Bits above WIDTH+CW are provably zero.
- **Stage mapping:**
  - STAGES=1: CSA tree and CLA are combinational, followed by one output register.
  - STAGES=2: register after the CSA tree (sum/carry vectors plus high bits), then CLA, then the output register.
  - STAGES=3: as for 2, and the CLA is split into low and high WIDTH/2 halves. The low half and its carry-out are registered in stage 2, and the high half is resolved in stage 3.
- **Handshake:**
  - Transfer in occurs when i_valid && o_ready.
  - Transfer out occurs when o_valid && i_ready.
  - Global pipeline enable en = !o_valid || i_ready, and o_ready = en && !i_rst.
  - When en=1, every stage register and its valid bit advance. A bubble (valid=0) propagates like data.
  - When en=0, all stages hold. o_summ and o_carry stay stable while o_valid && !i_ready.
  - i_ops and i_carry are ignored when the input transfer is not taken.
- **Reset:**
  - While i_rst=1, all stage valid bits, o_valid, o_summ and o_carry clear to 0, and o_ready=0.
  - Reset asserted mid-operation discards every in-flight result; no partial output appears.
  - The first acceptance is possible in the cycle after i_rst deasserts.
- **Simultaneous events:** output transfer and input transfer in the same cycle are legal and give full throughput.

## Timing
- Latency: a result accepted at edge t appears with o_valid=1 after edge t+STAGES-1, provided there is no stall. STAGES=1 gives o_valid in the cycle after acceptance.
- Throughput: 1 result per cycle with i_ready held high.
- Stall: each cycle with o_valid=1 and i_ready=0 adds exactly one cycle to every in-flight item. Order is preserved, and nothing is dropped or duplicated.
- o_ready depends combinationally on i_ready, o_valid and i_rst only, never on i_valid.
- Critical path (STAGES=2, WIDTH=32, N_OPS=5) is the 3-level CSA tree or the 32-bit CLA, whichever is longer.

## Structure
- Shared package sha_adder_pkg holds:
  - the default WIDTH/N_OPS constants;
  - the SHA-256 round-constant width;
  - a clog2-based function for CW.
- One sub-module, csa_3to2: a WIDTH-bit parametrised 3:2 compressor. It is instantiated N_OPS-2 times in a generate-built tree. i_carry enters as the LSB of the first compressor's carry vector.
- The final CLA is generate-built with per-bit generate/propagate, the same form as the existing adder.

## Test plan
- **All-ones overflow:** N_OPS=5, all ops 0xFFFFFFFF, i_carry=1 -> o_summ=0xFFFFFFFC, o_carry=4, o_valid after STAGES cycles.
- **SHA values:** ops = {0x6A09E667, 0xBB67AE85, 0, 0, 0}, i_carry=0 -> o_summ=0x257194EC, o_carry=1. All zero with i_carry=1 -> o_summ=1, o_carry=0.
- **Streaming:** 64 random back-to-back vectors with i_ready=1 -> o_valid continuously high after the fill latency, and every result matches the reference model in order.
- **Backpressure:** random i_ready (50%) -> o_summ/o_carry stable while stalled, o_ready=0 exactly when o_valid && !i_ready, and no loss or duplication.
- **Reset mid-flight:** STAGES=3 pipeline full, i_rst pulsed for 1 cycle -> o_valid=0, o_summ=0, o_carry=0 next cycle. No stale result emerges, and a new input is accepted the cycle after deassertion.
- **Parameter sweep:** (WIDTH, N_OPS, STAGES) ∈ {(8,2,1), (16,3,2), (32,8,3)} -> exhaustive corner operands (0, max, alternating 0xA5…) match the model, with o_carry never exceeding N_OPS-1.

Source files
------------

// File: rtl/sha_adder_pkg.sv
// Shared constants for the SHA-256 multi-operand adder and its compressor tree.
// calc_cw sizes the overflow count so N_OPS-1 always fits.
package sha_adder_pkg;

  localparam int SHA_WIDTH   = 32;
  localparam int SHA_N_OPS   = 5;
  localparam int SHA_K_WIDTH = 32;

  function automatic int calc_cw(input int n_ops);
    int cw;
    cw = $clog2(n_ops);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 compressor: a+b+c+cin == o_sum + o_cy (mod 2^WIDTH).
// o_cy is the majority vector already shifted left, with i_cin in its free LSB.
module csa_3to2
  import sha_adder_pkg::*;
#(
  parameter int WIDTH = SHA_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_cy
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_cy[0] = i_cin;

  // The majority out of the top bit is dropped: callers size WIDTH so the true sum never reaches it.
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_maj
    assign o_cy[gi] = (i_a[gi-1] & i_b[gi-1]) |
                      (i_a[gi-1] & i_c[gi-1]) |
                      (i_b[gi-1] & i_c[gi-1]);
  end

endmodule

// File: rtl/pipelined_multi_adder.sv
// Pipelined N-operand modulo-2^WIDTH adder: carry-save chain, then a g/p carry resolver,
// with one global enable so every stage advances or holds together.
module pipelined_multi_adder
  import sha_adder_pkg::*;
#(
  parameter  int WIDTH  = SHA_WIDTH,
  parameter  int N_OPS  = SHA_N_OPS,
  parameter  int STAGES = 2,
  localparam int CW     = calc_cw(N_OPS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N_OPS*WIDTH-1:0] i_ops,
  input  logic                   i_carry,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_summ,
  output logic [CW-1:0]          o_carry
);

  localparam int EW = WIDTH + CW;
  localparam int HW = WIDTH / 2;

  logic                       w_en;
  logic                       w_in_fire;
  logic [N_OPS-1:0][EW-1:0]   w_op;
  logic [EW-1:0]              w_csa_s;
  logic [EW-1:0]              w_csa_c;
  logic                       w_csa_cin;

  logic                       w_src_valid;
  logic [EW-1:0]              w_src_s;
  logic [EW-1:0]              w_src_c;
  logic                       w_src_cin;

  logic [EW-1:0]              w_cla_a;
  logic [EW-1:0]              w_cla_b;
  logic                       w_cla_cin;
  logic                       w_cla_cin_hi;
  logic [EW-1:0]              w_cla_sum;

  logic                       w_res_valid;
  logic [EW-1:0]              w_res;

  logic                       r_out_valid;
  logic [WIDTH-1:0]           r_summ;
  logic [CW-1:0]              r_carry;

  assign w_en      = !r_out_valid || i_ready;
  assign o_ready   = w_en && !i_rst;
  assign w_in_fire = i_valid && o_ready;

  for (genvar gi = 0; gi < N_OPS; gi++) begin : g_op
    assign w_op[gi] = EW'(i_ops[gi*WIDTH +: WIDTH]);
  end

  // Linear carry-save chain; each link folds in one more operand.
  for (genvar gi = 0; gi < N_OPS-2; gi++) begin : g_csa
    logic [EW-1:0] w_in_a;
    logic [EW-1:0] w_in_b;
    logic [EW-1:0] w_s;
    logic [EW-1:0] w_c;
    if (gi == 0) begin : g_first
      assign w_in_a = w_op[0];
      assign w_in_b = w_op[1];
    end else begin : g_next
      assign w_in_a = g_csa[gi-1].w_s;
      assign w_in_b = g_csa[gi-1].w_c;
    end
    csa_3to2 #(.WIDTH(EW)) u_csa (
      .i_a   (w_in_a),
      .i_b   (w_in_b),
      .i_c   (w_op[gi+2]),
      .i_cin ((gi == 0) ? i_carry : 1'b0),
      .o_sum (w_s),
      .o_cy  (w_c)
    );
  end

  if (N_OPS > 2) begin : g_tree_out
    assign w_csa_s   = g_csa[N_OPS-3].w_s;
    assign w_csa_c   = g_csa[N_OPS-3].w_c;
    assign w_csa_cin = 1'b0;
  end else begin : g_pair
    // No compressor to absorb the carry-in, so it goes straight to the resolver.
    assign w_csa_s   = w_op[0];
    assign w_csa_c   = w_op[1];
    assign w_csa_cin = i_carry;
  end

  if (STAGES == 1) begin : g_csa_comb
    assign w_src_valid = w_in_fire;
    assign w_src_s     = w_csa_s;
    assign w_src_c     = w_csa_c;
    assign w_src_cin   = w_csa_cin;
  end else begin : g_csa_reg
    logic          r_a_valid;
    logic [EW-1:0] r_a_s;
    logic [EW-1:0] r_a_c;
    logic          r_a_cin;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_a_valid <= 1'b0;
        r_a_s     <= '0;
        r_a_c     <= '0;
        r_a_cin   <= 1'b0;
      end else if (w_en) begin
        r_a_valid <= w_in_fire;
        r_a_s     <= w_csa_s;
        r_a_c     <= w_csa_c;
        r_a_cin   <= w_csa_cin;
      end
    end
    assign w_src_valid = r_a_valid;
    assign w_src_s     = r_a_s;
    assign w_src_c     = r_a_c;
    assign w_src_cin   = r_a_cin;
  end

  assign w_cla_cin = w_src_cin;

  // Per-bit generate/propagate; carry into bit HW is selectable so the adder can be cut in half.
  for (genvar gi = 0; gi < EW; gi++) begin : g_cla
    logic w_p;
    logic w_ci;
    assign w_p = w_cla_a[gi] ^ w_cla_b[gi];
    if (gi == 0) begin : g_ci0
      assign w_ci = w_cla_cin;
    end else if (gi == HW) begin : g_cimid
      assign w_ci = w_cla_cin_hi;
    end else begin : g_cin
      assign w_ci = g_cla[gi-1].g_co.w_co;
    end
    if (gi < EW-1) begin : g_co
      logic w_co;
      assign w_co = (w_cla_a[gi] & w_cla_b[gi]) | (w_p & w_ci);
    end
    assign w_cla_sum[gi] = w_p ^ w_ci;
  end

  if (STAGES == 3) begin : g_cla_split
    logic             r_b_valid;
    logic [HW-1:0]    r_b_lo;
    logic             r_b_co;
    logic [EW-HW-1:0] r_b_s_hi;
    logic [EW-HW-1:0] r_b_c_hi;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_b_valid <= 1'b0;
        r_b_lo    <= '0;
        r_b_co    <= 1'b0;
        r_b_s_hi  <= '0;
        r_b_c_hi  <= '0;
      end else if (w_en) begin
        r_b_valid <= w_src_valid;
        r_b_lo    <= w_cla_sum[HW-1:0];
        r_b_co    <= g_cla[HW-1].g_co.w_co;
        r_b_s_hi  <= w_src_s[EW-1:HW];
        r_b_c_hi  <= w_src_c[EW-1:HW];
      end
    end
    // Low half resolves the current item while the high half finishes the previous one.
    assign w_cla_a      = {r_b_s_hi, w_src_s[HW-1:0]};
    assign w_cla_b      = {r_b_c_hi, w_src_c[HW-1:0]};
    assign w_cla_cin_hi = r_b_co;
    assign w_res        = {w_cla_sum[EW-1:HW], r_b_lo};
    assign w_res_valid  = r_b_valid;
  end else begin : g_cla_full
    assign w_cla_a      = w_src_s;
    assign w_cla_b      = w_src_c;
    assign w_cla_cin_hi = g_cla[HW-1].g_co.w_co;
    assign w_res        = w_cla_sum;
    assign w_res_valid  = w_src_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_summ      <= '0;
      r_carry     <= '0;
    end else if (w_en) begin
      r_out_valid <= w_res_valid;
      r_summ      <= w_res[WIDTH-1:0];
      r_carry     <= w_res[EW-1:WIDTH];
    end
  end

  assign o_valid = r_out_valid;
  assign o_summ  = r_summ;
  assign o_carry = r_carry;

endmodule

// File: tb/tb_pipelined_multi_adder.sv
// Drives five adder configurations from one shared stimulus stream and scores each
// against a plain-arithmetic sum model with per-instance expected-result queues.
module tb_pipelined_multi_adder;

  localparam int NCFG = 5;
  localparam int CFG_W [NCFG] = '{32, 32, 8, 16, 32};
  localparam int CFG_N [NCFG] = '{5, 5, 2, 3, 8};
  localparam int CFG_S [NCFG] = '{2, 3, 1, 2, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_valid;
  logic        tb_ready;
  logic        stim_carry;
  logic [31:0] stim_ops [8];
  logic [31:0] corners [4];
  logic [63:0] exp_q [NCFG][$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact unsigned sum of the first n operands (each truncated to w bits) plus carry-in.
  function automatic logic [63:0] model(input int n, input int w);
    logic [63:0] s;
    s = 64'(stim_carry);
    for (int k = 0; k < n; k++) s += 64'(stim_ops[k]) & ((64'd1 << w) - 64'd1);
    return s;
  endfunction

  task automatic rand_stim();
    for (int k = 0; k < 8; k++) stim_ops[k] = $urandom();
    stim_carry = 1'($urandom_range(0, 1));
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int W   = CFG_W[gi];
    localparam int N   = CFG_N[gi];
    localparam int S   = CFG_S[gi];
    localparam int CWL = ($clog2(N) < 1) ? 1 : $clog2(N);

    logic [N*W-1:0] w_ops;
    logic           w_oready;
    logic           w_ovalid;
    logic [W-1:0]   w_summ;
    logic [CWL-1:0] w_carry;
    logic           prev_stall = 1'b0;
    logic [W-1:0]   prev_summ;
    logic [CWL-1:0] prev_carry;

    for (genvar gk = 0; gk < N; gk++) begin : g_op
      assign w_ops[gk*W +: W] = stim_ops[gk][W-1:0];
    end

    pipelined_multi_adder #(.WIDTH(W), .N_OPS(N), .STAGES(S)) u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (tb_valid),
      .o_ready (w_oready),
      .i_ops   (w_ops),
      .i_carry (stim_carry),
      .o_valid (w_ovalid),
      .i_ready (tb_ready),
      .o_summ  (w_summ),
      .o_carry (w_carry)
    );

    always @(negedge clk) begin : mon
      logic [63:0] exp_v;
      if (rst) begin
        chk($sformatf("c%0d_oready_rst", gi), 64'(w_oready), 64'(0));
        exp_q[gi].delete();
        prev_stall = 1'b0;
      end else begin
        chk($sformatf("c%0d_oready", gi), 64'(w_oready), 64'(!(w_ovalid && !tb_ready)));
        if (prev_stall) begin
          chk($sformatf("c%0d_stall_valid", gi), 64'(w_ovalid), 64'(1));
          chk($sformatf("c%0d_stall_summ", gi), 64'(w_summ), 64'(prev_summ));
          chk($sformatf("c%0d_stall_carry", gi), 64'(w_carry), 64'(prev_carry));
        end
        if (w_ovalid && tb_ready) begin
          if (exp_q[gi].size() == 0) begin
            chk($sformatf("c%0d_spurious", gi), 64'(w_ovalid), 64'(0));
          end else begin
            exp_v = exp_q[gi].pop_front();
            $display("c%0d out summ=0x%0h carry=%0d", gi, w_summ, w_carry);
            chk($sformatf("c%0d_summ", gi), 64'(w_summ), exp_v & ((64'd1 << W) - 64'd1));
            chk($sformatf("c%0d_carry", gi), 64'(w_carry), exp_v >> W);
            chk($sformatf("c%0d_ovf_bound", gi), 64'(int'(w_carry) <= N - 1), 64'(1));
          end
        end
        if (tb_valid && w_oready) exp_q[gi].push_back(model(N, W));
        prev_stall = w_ovalid && !tb_ready;
        prev_summ  = w_summ;
        prev_carry = w_carry;
      end
    end
  end

  // One transaction into an idle pipeline; checks DUT0 latency and result against constants.
  task automatic directed(input string tag, input logic [31:0] exp_s, input logic [2:0] exp_c);
    int n;
    tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!g_dut[0].w_ovalid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(n), 64'(1));
    chk({tag, "_summ"}, 64'(g_dut[0].w_summ), 64'(exp_s));
    chk({tag, "_carry"}, 64'(g_dut[0].w_carry), 64'(exp_c));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'hA5A5_A5A5;
    corners[3] = 32'h5A5A_5A5A;
    rst        = 1'b1;
    tb_valid   = 1'b0;
    tb_ready   = 1'b1;
    stim_carry = 1'b0;
    for (int k = 0; k < 8; k++) stim_ops[k] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(g_dut[0].w_ovalid), 64'(0));
    chk("reset_summ", 64'(g_dut[0].w_summ), 64'(0));
    chk("reset_carry", 64'(g_dut[0].w_carry), 64'(0));
    chk("reset_ready", 64'(g_dut[0].w_oready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 8; k++) stim_ops[k] = 32'hFFFF_FFFF;
    stim_carry = 1'b1;
    directed("all_ones", 32'hFFFF_FFFC, 3'd4);

    for (int k = 0; k < 8; k++) stim_ops[k] = '0;
    stim_ops[0] = 32'h6A09_E667;
    stim_ops[1] = 32'hBB67_AE85;
    stim_carry  = 1'b0;
    directed("sha", 32'h2571_94EC, 3'd1);

    stim_ops[0] = '0;
    stim_ops[1] = '0;
    stim_carry  = 1'b1;
    directed("zero_cin", 32'h0000_0001, 3'd0);

    // Back-to-back stream: output valid must stay high once the pipe has filled.
    for (int i = 0; i < 64; i++) begin
      rand_stim();
      tb_valid = 1'b1;
      @(negedge clk);
      if (i >= 2) chk("stream_valid_s2", 64'(g_dut[0].w_ovalid), 64'(1));
      if (i >= 3) chk("stream_valid_s3", 64'(g_dut[1].w_ovalid), 64'(1));
      @(posedge clk); #1;
    end
    tb_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      rand_stim();
      tb_valid = ($urandom_range(0, 3) != 0);
      tb_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    tb_valid = 1'b0;
    tb_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    for (int i = 0; i < 48; i++) begin
      for (int k = 0; k < 8; k++) stim_ops[k] = (i < 8) ? corners[i / 2] : corners[$urandom_range(0, 3)];
      stim_carry = (i < 8) ? 1'(i % 2) : 1'($urandom_range(0, 1));
      tb_valid   = 1'b1;
      @(posedge clk); #1;
    end
    tb_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Fill the pipes, pulse reset for one cycle, then present a fresh item immediately.
    for (int i = 0; i < 6; i++) begin
      rand_stim();
      tb_valid = 1'b1;
      @(posedge clk); #1;
    end
    rand_stim();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rand_stim();
    tb_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 64'(g_dut[1].w_ovalid), 64'(0));
    chk("rst_mid_summ", 64'(g_dut[1].w_summ), 64'(0));
    chk("rst_mid_carry", 64'(g_dut[1].w_carry), 64'(0));
    chk("rst_mid_ready", 64'(g_dut[1].w_oready), 64'(1));
    @(posedge clk); #1;
    tb_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!g_dut[1].w_ovalid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("rst_new_lat", 64'(n), 64'(2));
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < NCFG; i++) chk($sformatf("drain%0d", i), 64'(exp_q[i].size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
